hht_col_writeback: RTL

Downstream stage of the HHT column controller. Accepts the stream of transformed column elements produced by the controller, buffers them in a small FIFO, and writes them back to data memory at consecutive addresses `out_base .. out_base+csize-1`. Decouples compute from memory stalls. Signals completion of each column with a one-cycle `done` pulse.

---
 rtl/hht_col_writeback.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hht_col_writeback.sv
// Column write-back stage: buffers transformed column elements in a small FIFO and
// writes them to consecutive memory addresses, pulsing done once per finished column.
module hht_col_writeback #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic [31:0]              out_base,
    input  logic [31:0]              csize,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [31:0]              wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_ack,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       csize_q, csize_d;
    logic [31:0]       in_cnt_q, in_cnt_d;
    logic [31:0]       wr_idx_q, wr_idx_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == LW'(DEPTH));
    assign empty = (count_q == '0);

    // Handshakes depend only on registered state, never on in_valid or wr_ack.
    assign in_ready = (state_q == ST_RUN) && !full && (in_cnt_q < csize_q);
    assign wr_en    = (state_q == ST_RUN) && !empty;
    assign push     = in_valid && in_ready;
    assign pop      = wr_en && wr_ack;

    assign wr_addr = wr_en ? (base_q + wr_idx_q) : '0;
    assign wr_data = wr_en ? mem_q[rd_ptr_q] : '0;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign level   = count_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        csize_d  = csize_q;
        in_cnt_d = in_cnt_q;
        wr_idx_d = wr_idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = out_base;
                    csize_d  = csize;
                    in_cnt_d = '0;
                    wr_idx_d = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = (csize != 32'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    in_cnt_d = in_cnt_q + 32'd1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    wr_idx_d = wr_idx_q + 32'd1;
                end
                if (push && !pop) begin
                    count_d = count_q + LW'(1);
                end else if (pop && !push) begin
                    count_d = count_q - LW'(1);
                end
                // Every accepted element has been written once the final pop lands.
                if (pop && ((wr_idx_q + 32'd1) == csize_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            csize_q  <= '0;
            in_cnt_q <= '0;
            wr_idx_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            csize_q  <= csize_d;
            in_cnt_q <= in_cnt_d;
            wr_idx_q <= wr_idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable because wr_data is gated by wr_en.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
